// File: rtl/mem_bus_ram_pkg.sv
// Shared memory-bus types used by the caches and by the mem_bus_ram responder.
package mem_bus_ram_pkg;

  typedef logic [31:0] Addr;
  typedef logic [31:0] UInt32;

  typedef struct packed {
    logic  valid;
    Addr   addr;
    logic  wen;
    UInt32 wdata;
  } MemBusReq;

  typedef struct packed {
    logic  valid;
    UInt32 rdata;
  } MemBusResp;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    RESP       = 2'd2,
    WRITE_WAIT = 2'd3
  } ram_state_e;

  localparam int CNT_W       = 4;
  localparam int MAX_LATENCY = 15;

endpackage

// File: rtl/mem_bus_ram_array.sv
// Single-port synchronous RAM, 2^AW x 32, write-first read port.
module mem_bus_ram_array
  import mem_bus_ram_pkg::*;
#(
  parameter int    AW        = 16,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  UInt32         wdata_i,
  output UInt32         rdata_o
);

  UInt32 mem_q [0:(1<<AW)-1];
  UInt32 rdata_q;

  // No reset on purpose: RAM contents and its read register survive rst_n.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_ram.sv
// Bus responder around mem_bus_ram_array: one request at a time, fixed read/write latency.
// state      | meaning
// IDLE       | ready high, accepting a request
// READ_WAIT  | word latched, counting down read latency
// RESP       | busresp valid for exactly this cycle
// WRITE_WAIT | write done, holding ready low for write latency
module mem_bus_ram
  import mem_bus_ram_pkg::*;
#(
  parameter int    MEM_WIDTH     = 16,
  parameter int    READ_LATENCY  = 2,
  parameter int    WRITE_LATENCY = 1,
  parameter string INIT_FILE     = ""
) (
  input  logic      clk,
  input  logic      rst_n,
  input  MemBusReq  busreq_i,
  output logic      busreq_ready_o,
  output MemBusResp busresp_o
);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_LATENCY ||
      WRITE_LATENCY < 0 || WRITE_LATENCY > MAX_LATENCY ||
      MEM_WIDTH < 1 || MEM_WIDTH > 29) begin : g_param_check
    $fatal(1, "mem_bus_ram: parameter out of range");
  end

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  ram_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  UInt32            resp_rdata_q, resp_rdata_d;
  logic             accept;
  UInt32            arr_rdata;
  logic             unused_addr;

  assign busreq_ready_o = (state_q == IDLE) && rst_n;
  assign accept         = busreq_i.valid && busreq_ready_o;
  assign unused_addr    = ^{busreq_i.addr[1:0], busreq_i.addr[31:MEM_WIDTH+2]};

  mem_bus_ram_array #(
    .AW        (MEM_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .en_i    (accept),
    .we_i    (busreq_i.wen),
    .addr_i  (busreq_i.addr[MEM_WIDTH+1:2]),
    .wdata_i (busreq_i.wdata),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (busreq_i.wen) begin
            if (WRITE_LATENCY != 0) begin
              state_d = WRITE_WAIT;
              cnt_d   = WR_LOAD;
            end
          end else begin
            state_d = READ_WAIT;
            cnt_d   = RD_LOAD;
          end
        end
      end
      WRITE_WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      READ_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = arr_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign busresp_o.valid = resp_valid_q;
  assign busresp_o.rdata = resp_rdata_q;

  a_single_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    busresp_o.valid |=> !busresp_o.valid);

endmodule

// File: tb/tb_mem_bus_ram.sv
// Scoreboard bench for mem_bus_ram across several latency/width configurations.
module tb_mem_bus_ram;
  import mem_bus_ram_pkg::*;

  localparam int N = 5;
  localparam int RL [N] = '{2, 4, 1, 3, 15};

  logic      clk = 1'b0;
  logic      rstn [N];
  MemBusReq  req  [N];
  logic      rdy  [N];
  MemBusResp rsp  [N];
  int        cyc = 0;
  int        total = 0;
  int        bad = 0;

  typedef struct {
    int    dev;
    UInt32 data;
    int    due;
    string name;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_ram #(.MEM_WIDTH(16), .READ_LATENCY(2), .WRITE_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rstn[0]), .busreq_i(req[0]), .busreq_ready_o(rdy[0]), .busresp_o(rsp[0]));
  mem_bus_ram #(.MEM_WIDTH(4), .READ_LATENCY(4), .WRITE_LATENCY(0)) u_dut1 (
    .clk(clk), .rst_n(rstn[1]), .busreq_i(req[1]), .busreq_ready_o(rdy[1]), .busresp_o(rsp[1]));
  mem_bus_ram #(.MEM_WIDTH(8), .READ_LATENCY(1), .WRITE_LATENCY(1)) u_dut2 (
    .clk(clk), .rst_n(rstn[2]), .busreq_i(req[2]), .busreq_ready_o(rdy[2]), .busresp_o(rsp[2]));
  mem_bus_ram #(.MEM_WIDTH(8), .READ_LATENCY(3), .WRITE_LATENCY(2)) u_dut3 (
    .clk(clk), .rst_n(rstn[3]), .busreq_i(req[3]), .busreq_ready_o(rdy[3]), .busresp_o(rsp[3]));
  mem_bus_ram #(.MEM_WIDTH(8), .READ_LATENCY(15), .WRITE_LATENCY(1)) u_dut4 (
    .clk(clk), .rst_n(rstn[4]), .busreq_i(req[4]), .busreq_ready_o(rdy[4]), .busresp_o(rsp[4]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (rsp[d].valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp dev=%0d actual valid=1 required valid=0", d);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, "_dev"}, d, mon_e.dev);
          chk({mon_e.name, "_data"}, rsp[d].rdata, mon_e.data);
          chk({mon_e.name, "_cycle"}, cyc, mon_e.due);
        end
      end
    end
    if (sb.size() != 0 && sb[0].due < cyc) begin
      mon_e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no response by cycle %0d required=response at cycle %0d",
               mon_e.name, cyc, mon_e.due);
    end
  end

  task automatic issue(input int d, input logic wen, input Addr a, input UInt32 wd,
                       input UInt32 exp, input bit push, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rdy[d] !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_ready_wait actual=%b required=1", name, rdy[d]);
    end else begin
      req[d].valid = 1'b1;
      req[d].wen   = wen;
      req[d].addr  = a;
      req[d].wdata = wd;
      @(posedge clk);
      #1;
      req[d].valid = 1'b0;
      if (!wen && push) sb.push_back('{dev: d, data: exp, due: cyc + RL[d], name: name});
    end
  endtask

  task automatic wr(input int d, input Addr a, input UInt32 wd, input string name);
    issue(d, 1'b1, a, wd, 32'h0, 1'b0, name);
  endtask

  // Read plus ready profile: low from the accept cycle through the pulse, high right after.
  task automatic rd_track(input int d, input Addr a, input UInt32 exp, input string name);
    issue(d, 1'b0, a, 32'h0, exp, 1'b1, name);
    for (int i = 0; i <= RL[d]; i++) begin
      @(negedge clk);
      chk({name, "_ready_low"}, rdy[d], 1'b0);
    end
    @(negedge clk);
    chk({name, "_ready_back"}, rdy[d], 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < N; d++) begin
      rstn[d] = 1'b0;
      req[d]  = '0;
    end

    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", rdy[0], 1'b0);
      chk("rst_valid", rsp[0].valid, 1'b0);
    end
    chk("rst_rdata", rsp[0].rdata, 32'h0);
    for (int d = 0; d < N; d++) rstn[d] = 1'b1;
    #1;
    chk("rel_ready_now", rdy[0], 1'b1);
    @(negedge clk);
    chk("rel_ready", rdy[0], 1'b1);

    wr(0, 32'h0000_0010, 32'hDEAD_BEEF, "wr_def");
    @(negedge clk);
    chk("wr_def_busy", rdy[0], 1'b0);
    @(negedge clk);
    chk("wr_def_free", rdy[0], 1'b1);
    rd_track(0, 32'h0000_0010, 32'hDEAD_BEEF, "rd_def");

    wr(1, 32'h0000_0044, 32'h1234_5678, "wr_wrap");
    rd_track(1, 32'h0000_0004, 32'h1234_5678, "rd_wrap");
    rd_track(1, 32'h0000_0007, 32'h1234_5678, "rd_wrap_lsb");

    wr(1, 32'h0000_0000, 32'hAAAA_0001, "wr_b2b0");
    chk("b2b_ready", rdy[1], 1'b1);
    wr(1, 32'h0000_0004, 32'hBBBB_0002, "wr_b2b1");
    rd_track(1, 32'h0000_0000, 32'hAAAA_0001, "rd_b2b0");
    rd_track(1, 32'h0000_0004, 32'hBBBB_0002, "rd_b2b1");

    wr(1, 32'h0000_0008, 32'hCAFE_F00D, "wr_prst");
    issue(1, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b0, "rd_aborted");
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn[1] = 1'b0;
    #1;
    chk("midrst_ready", rdy[1], 1'b0);
    chk("midrst_valid", rsp[1].valid, 1'b0);
    repeat (2) @(negedge clk);
    rstn[1] = 1'b1;
    repeat (8) @(negedge clk);
    rd_track(1, 32'h0000_0008, 32'hCAFE_F00D, "rd_after_rst");

    wr(2, 32'h0000_0100, 32'h0BAD_F00D, "wr_rl1");
    rd_track(2, 32'h0000_0100, 32'h0BAD_F00D, "rd_rl1");
    wr(3, 32'h0000_003C, 32'hA5A5_5A5A, "wr_rl3");
    rd_track(3, 32'h0000_003C, 32'hA5A5_5A5A, "rd_rl3");
    wr(4, 32'h0000_FFFC, 32'h1357_9BDF, "wr_rl15");
    rd_track(4, 32'h0000_03FC, 32'h1357_9BDF, "rd_rl15");

    repeat (20) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
